gem_rx_w_frame_tracker: RTL and testbench
=========================================

// Module: gem_rx_w_frame_tracker
// PURPOSE
//  Sits directly on the GEM RX FIFO write interface (rx_w_*), upstream of gem_rx_w_status_encoder.
//  Forwards 32-bit payload words to the RX data buffer and counts the frame length in bytes.
//  Captures rx_w_status at end of frame and queues one {status, frame_length, flags} record per frame.
//  The queued record is the input to the status encoder. The GEM cannot be stalled, so any loss is handled by drop-and-flag.
// PARAMETERS
//  STATUS_DEPTH  4     entries in the per-frame status queue (power of 2, >=2)
//  MAX_FRAME     8191  byte count saturation limit (fits 13 bits)
// PORTS
//  clock          in   1   single clock domain
//  resetn         in   1   synchronous reset, active-low
//  rx_w_wr        in   1   GEM write strobe, one data word per cycle when high
//  rx_w_data      in   32  payload word, little-endian byte order
//  rx_w_sop       in   1   qualifies first word (valid with rx_w_wr)
//  rx_w_eop       in   1   qualifies last word (valid with rx_w_wr)
//  rx_w_err       in   1   frame error, sampled with eop
//  rx_w_flush     in   1   GEM requests discard of current frame
//  rx_w_status    in   45  GEM frame status, valid in the eop cycle
//  rx_w_overflow  out  1   one-cycle pulse to GEM: current frame lost
//  m_data         out  32  word to RX data buffer
//  m_last         out  1   marks last word of frame
//  m_valid        out  1   m_data valid
//  m_ready        in   1   buffer accepts word
//  s_status       out  45  captured rx_w_status
//  s_frame_length out  13  byte count, feeds encoder frame_length
//  s_dropped      out  1   frame truncated/flushed/overflowed; payload invalid
//  s_len_mismatch out  1   counted bytes != rx_w_status[13:0]
//  s_valid        out  1   status record available
//  s_ready        in   1   consumer pops record
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; queue empty.
//  FSM: IDLE -> FRAME on wr&sop; FRAME -> IDLE on wr&eop; FRAME -> DROP on overflow or flush;
//   DROP -> IDLE on wr&eop; IDLE/DROP with flush stays put. wr&sop in FRAME: abort old frame
//   (push record with s_dropped=1, length so far), start new frame same cycle.
//  Data path: one output register; word loaded when wr and register empty or m_ready high that cycle.
//   Latency rx_w_wr -> m_valid = 1 cycle. wr while register full and !m_ready = overflow.
//  Overflow: pulse rx_w_overflow 1 cycle, enter DROP, discard remaining words; m_last forced on
//   the held word if present so the buffer can close the frame.
//  Length: +4 per non-eop word; eop word adds rx_w_status[1:0] (0 means 4). Saturate at MAX_FRAME.
//   s_len_mismatch = (count != rx_w_status[13:0]) when not dropped, else 0.
//  Status push at eop (or abort): if queue full, record lost, rx_w_overflow pulses, no other effect.
//  Queue: FIFO, s_valid = !empty, pop on s_valid&s_ready; push and pop same cycle when full legal
//   (pop first). s_* are registered head-of-queue values, stable while s_valid&!s_ready.
//  rx_w_err at eop: s_dropped=1. wr without sop in IDLE: ignored. wr with sop&eop: 1-word frame.
//  Mid-frame reset: frame discarded, nothing pushed, no rx_w_overflow pulse.
// STRUCTURE
//  gem_rx_pkg: GEM_RX_W_STATUS_WIDTH=45, GEM_RX_W_STATUS_FRAME_LENGTH_WIDTH=14,
//   rx_tracker_state_t enum {IDLE,FRAME,DROP}, packed struct rx_frame_record_t.
//  Sub-module: gem_rx_status_fifo (sync FIFO of rx_frame_record_t, depth STATUS_DEPTH).
// TESTING
//  64-byte frame, 16 words, status[13:0]=64, m_ready=1 -> 16 words, m_last on 16th, len 64, mismatch 0.
//  61-byte frame, status[1:0]=1 -> s_frame_length=61; status[13:0]=60 -> s_len_mismatch=1.
//  m_ready=0 at word 3 of 10 -> rx_w_overflow pulse at word 4, s_dropped=1, 3 words emitted.
//  rx_w_flush at word 5 -> DROP, record s_dropped=1; next sop frame tracked normally.
//  s_ready=0, 5 back-to-back frames, depth 4 -> 4 records kept, 5th pulses rx_w_overflow.
//  resetn low mid-frame -> all outputs 0 next cycle, queue empty, no record pushed.

Source files
------------

// File: rtl/gem_rx_pkg.sv
// Shared types for the GEM RX write-side frame tracker.
//  - GEM status widths
//  - tracker FSM state
//  - per-frame record queued towards the status encoder
//  - helper that decodes the byte count of the final word of a frame
package gem_rx_pkg;

    localparam int unsigned GEM_RX_W_STATUS_WIDTH              = 45;
    localparam int unsigned GEM_RX_W_STATUS_FRAME_LENGTH_WIDTH = 14;
    localparam int unsigned GEM_RX_FRAME_LEN_WIDTH             = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } rx_tracker_state_t;

    typedef struct packed {
        logic [GEM_RX_W_STATUS_WIDTH-1:0]  status;
        logic [GEM_RX_FRAME_LEN_WIDTH-1:0] frame_length;
        logic                              dropped;
        logic                              len_mismatch;
    } rx_frame_record_t;

    // Valid bytes in the eop word: the low two status bits, where 0 means a full word.
    function automatic logic [2:0] eop_bytes(input logic [1:0] mod);
        return (mod == 2'd0) ? 3'd4 : {1'b0, mod};
    endfunction

endpackage

// File: rtl/gem_rx_status_fifo.sv
// Synchronous FIFO of per-frame records.
//  clock        in   single clock domain
//  resetn       in   synchronous active-low reset, empties the queue and clears storage
//  push_i       in   write push_data_i this cycle
//  push_data_i  in   record to enqueue
//  pop_i        in   remove head this cycle (ignored when empty)
//  push_drop_o  out  push requested but queue full with no pop: record lost
//  empty_o      out  queue empty
//  head_o       out  head-of-queue record (registered storage, stable until popped)
module gem_rx_status_fifo
    import gem_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push_i,
    input  rx_frame_record_t push_data_i,
    input  logic             pop_i,
    output logic             push_drop_o,
    output logic             empty_o,
    output rx_frame_record_t head_o
);

    localparam int unsigned      PtrW      = $clog2(DEPTH);
    localparam logic [PtrW:0]    FullCount = DEPTH[PtrW:0];

    rx_frame_record_t mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_pop, do_push;

    // Pop is evaluated first so a full queue can accept a push in the same cycle.
    assign do_pop      = pop_i && (count_q != '0);
    assign do_push     = push_i && ((count_q != FullCount) || do_pop);
    assign push_drop_o = push_i && !do_push;
    assign empty_o     = (count_q == '0);
    assign head_o      = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/gem_rx_w_frame_tracker.sv
// GEM RX FIFO write-side frame tracker.
// Forwards payload words through a single output register, counts frame bytes and queues one
// {status, length, dropped, len_mismatch} record per frame for the status encoder. The GEM
// cannot be stalled, so any loss is reported on rx_w_overflow and flagged in the record.
//  clock, resetn            single clock, synchronous active-low reset
//  rx_w_wr/data/sop/eop     GEM write interface, one word per cycle
//  rx_w_err, rx_w_status    frame error and status, valid with eop
//  rx_w_flush               discard current frame
//  rx_w_overflow            one-cycle loss pulse back to the GEM
//  m_data/m_last/m_valid    payload towards the RX data buffer, m_ready backpressure
//  s_status/s_frame_length/s_dropped/s_len_mismatch/s_valid   head-of-queue record
//  s_ready                  consumer pops the record
module gem_rx_w_frame_tracker
    import gem_rx_pkg::*;
#(
    parameter int unsigned STATUS_DEPTH = 4,
    parameter int unsigned MAX_FRAME    = 8191
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        rx_w_wr,
    input  logic [31:0] rx_w_data,
    input  logic        rx_w_sop,
    input  logic        rx_w_eop,
    input  logic        rx_w_err,
    input  logic        rx_w_flush,
    input  logic [44:0] rx_w_status,
    output logic        rx_w_overflow,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [44:0] s_status,
    output logic [12:0] s_frame_length,
    output logic        s_dropped,
    output logic        s_len_mismatch,
    output logic        s_valid,
    input  logic        s_ready
);

    localparam logic [13:0] MaxLen = MAX_FRAME[13:0];

    rx_tracker_state_t state_q, state_d;
    logic [12:0]       count_q, count_d;
    logic [31:0]       m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic              m_valid_q, m_valid_d;
    logic              ovf_q, ovf_d;

    logic              start;
    logic              blocked;
    logic [2:0]        word_bytes;
    logic [13:0]       base;
    logic [13:0]       sum;
    logic [12:0]       len_now;

    logic              take;
    logic              abort;
    logic              frame_push;
    logic              push;
    logic              push_drop;
    logic              fifo_empty;
    rx_frame_record_t  abort_rec;
    rx_frame_record_t  frame_rec;
    rx_frame_record_t  push_rec;
    rx_frame_record_t  head;

    assign start      = rx_w_wr && rx_w_sop;
    // Register holds a word the buffer is not taking this cycle: a new word would be lost.
    assign blocked    = m_valid_q && !m_ready;
    assign word_bytes = rx_w_eop ? eop_bytes(rx_w_status[1:0]) : 3'd4;
    // Length including the current word; a sop word restarts the count.
    assign base       = start ? 14'd0 : {1'b0, count_q};
    assign sum        = base + {11'b0, word_bytes};
    assign len_now    = (sum > MaxLen) ? MaxLen[12:0] : sum[12:0];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        m_valid_d  = m_valid_q && !m_ready;
        ovf_d      = 1'b0;
        take       = 1'b0;
        abort      = 1'b0;
        frame_push = 1'b0;
        abort_rec  = '0;
        frame_rec  = '0;

        unique case (state_q)
            IDLE: begin
                if (!rx_w_flush && start) begin
                    take = 1'b1;
                end
            end
            FRAME: begin
                if (rx_w_flush) begin
                    abort   = 1'b1;
                    state_d = DROP;
                end else if (rx_w_wr) begin
                    take  = 1'b1;
                    abort = rx_w_sop;
                end
            end
            DROP: begin
                if (!rx_w_flush) begin
                    if (start) begin
                        take = 1'b1;
                    end else if (rx_w_wr && rx_w_eop) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abandoned frame: status is not valid outside eop, so it is recorded as zero.
        abort_rec.frame_length = count_q;
        abort_rec.dropped      = 1'b1;

        if (take) begin
            count_d = len_now;
            if (blocked) begin
                // Word lost: close the held word so the buffer can end the frame.
                ovf_d                  = 1'b1;
                m_last_d               = 1'b1;
                frame_push             = 1'b1;
                frame_rec.status       = rx_w_eop ? rx_w_status : '0;
                frame_rec.frame_length = len_now;
                frame_rec.dropped      = 1'b1;
                state_d                = rx_w_eop ? IDLE : DROP;
            end else begin
                m_data_d  = rx_w_data;
                m_last_d  = rx_w_eop;
                m_valid_d = 1'b1;
                if (rx_w_eop) begin
                    frame_push             = 1'b1;
                    frame_rec.status       = rx_w_status;
                    frame_rec.frame_length = len_now;
                    frame_rec.dropped      = rx_w_err;
                    frame_rec.len_mismatch = !rx_w_err && ({1'b0, len_now} != rx_w_status[13:0]);
                    state_d                = IDLE;
                end else begin
                    state_d = FRAME;
                end
            end
        end

        // One push port: when an abort and a completed/lost frame coincide, the abort record
        // wins and the second record is reported as lost.
        push     = abort || frame_push;
        push_rec = abort ? abort_rec : frame_rec;
        if ((abort && frame_push) || push_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    gem_rx_status_fifo #(
        .DEPTH (STATUS_DEPTH)
    ) u_status_fifo (
        .clock       (clock),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i (push_rec),
        .pop_i       (s_ready),
        .push_drop_o (push_drop),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign rx_w_overflow  = ovf_q;
    assign m_data         = m_data_q;
    assign m_last         = m_last_q;
    assign m_valid        = m_valid_q;
    assign s_status       = head.status;
    assign s_frame_length = head.frame_length;
    assign s_dropped      = head.dropped;
    assign s_len_mismatch = head.len_mismatch;
    assign s_valid        = !fifo_empty;

endmodule

// File: tb/tb_gem_rx_w_frame_tracker.sv
module tb_gem_rx_w_frame_tracker;

    logic        clock = 1'b0;
    logic        resetn;
    logic        rx_w_wr;
    logic [31:0] rx_w_data;
    logic        rx_w_sop;
    logic        rx_w_eop;
    logic        rx_w_err;
    logic        rx_w_flush;
    logic [44:0] rx_w_status;
    logic        rx_w_overflow;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic [44:0] s_status;
    logic [12:0] s_frame_length;
    logic        s_dropped;
    logic        s_len_mismatch;
    logic        s_valid;
    logic        s_ready;

    int n_vec = 0;
    int n_err = 0;

    // Monitor: cumulative counts, tests look at deltas.
    int          acc_cnt  = 0;
    int          last_cnt = 0;
    int          ovf_cnt  = 0;
    logic [31:0] last_data = '0;

    always #5 clock = ~clock;

    gem_rx_w_frame_tracker dut (
        .clock          (clock),
        .resetn         (resetn),
        .rx_w_wr        (rx_w_wr),
        .rx_w_data      (rx_w_data),
        .rx_w_sop       (rx_w_sop),
        .rx_w_eop       (rx_w_eop),
        .rx_w_err       (rx_w_err),
        .rx_w_flush     (rx_w_flush),
        .rx_w_status    (rx_w_status),
        .rx_w_overflow  (rx_w_overflow),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .s_status       (s_status),
        .s_frame_length (s_frame_length),
        .s_dropped      (s_dropped),
        .s_len_mismatch (s_len_mismatch),
        .s_valid        (s_valid),
        .s_ready        (s_ready)
    );

    always @(posedge clock) begin
        if (resetn) begin
            if (m_valid && m_ready) begin
                acc_cnt   <= acc_cnt + 1;
                last_data <= m_data;
                if (m_last) last_cnt <= last_cnt + 1;
            end
            if (rx_w_overflow) ovf_cnt <= ovf_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rx_w_wr     = 1'b0;
        rx_w_data   = '0;
        rx_w_sop    = 1'b0;
        rx_w_eop    = 1'b0;
        rx_w_err    = 1'b0;
        rx_w_flush  = 1'b0;
        rx_w_status = '0;
    endtask

    task automatic drive_word(input logic [31:0] d, input logic sop, input logic eop,
                              input logic [44:0] st, input logic err);
        rx_w_wr     = 1'b1;
        rx_w_data   = d;
        rx_w_sop    = sop;
        rx_w_eop    = eop;
        rx_w_status = eop ? st : 45'd0;
        rx_w_err    = eop ? err : 1'b0;
    endtask

    // Words are {id, index}; eop only if with_eop. Ends at a negedge with inputs idle.
    task automatic send_frame(input int nwords, input logic [44:0] st, input logic err,
                              input logic [15:0] id, input logic with_eop);
        for (int i = 0; i < nwords; i++) begin
            @(negedge clock);
            drive_word({id, 16'(i)}, i == 0, with_eop && (i == nwords - 1), st, err);
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic pop_rec(input string tag, input logic [12:0] len, input logic drop,
                           input logic mm, input logic [44:0] st);
        check_eq({tag, ".valid"}, s_valid, 1);
        check_eq({tag, ".len"}, s_frame_length, len);
        check_eq({tag, ".dropped"}, s_dropped, drop);
        check_eq({tag, ".mismatch"}, s_len_mismatch, mm);
        check_eq({tag, ".status"}, s_status, st);
        s_ready = 1'b1;
        @(negedge clock);
        s_ready = 1'b0;
    endtask

    initial begin
        int a0, l0, o0;
        logic [44:0] st;

        resetn  = 1'b0;
        m_ready = 1'b1;
        s_ready = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clock);
        check_eq("rst.m_valid", m_valid, 0);
        check_eq("rst.m_data", m_data, 0);
        check_eq("rst.s_valid", s_valid, 0);
        check_eq("rst.len", s_frame_length, 0);
        check_eq("rst.ovf", rx_w_overflow, 0);
        resetn = 1'b1;

        // wr without sop in IDLE is ignored
        @(negedge clock);
        drive_word(32'hDEAD_BEEF, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clock);
        idle_inputs();
        check_eq("nosop.m_valid", m_valid, 0);

        // 64-byte frame
        a0 = acc_cnt; l0 = last_cnt; o0 = ovf_cnt;
        st = {31'h5A5A, 14'd64};
        send_frame(16, st, 1'b0, 16'd1, 1'b1);
        @(negedge clock);
        check_eq("f64.words", acc_cnt - a0, 16);
        check_eq("f64.last", last_cnt - l0, 1);
        check_eq("f64.lastdata", last_data, {16'd1, 16'd15});
        check_eq("f64.ovf", ovf_cnt - o0, 0);
        pop_rec("f64", 13'd64, 1'b0, 1'b0, st);
        check_eq("f64.empty", s_valid, 0);

        // 61-byte frame, status matches
        st = {31'h0, 14'd61};
        send_frame(16, st, 1'b0, 16'd2, 1'b1);
        pop_rec("f61", 13'd61, 1'b0, 1'b0, st);

        // counted 64, GEM claims 60
        st = {31'h7, 14'd60};
        send_frame(16, st, 1'b0, 16'd3, 1'b1);
        pop_rec("mm", 13'd64, 1'b0, 1'b1, st);

        // error at eop
        st = {31'h0, 14'd16};
        send_frame(4, st, 1'b1, 16'd4, 1'b1);
        pop_rec("err", 13'd16, 1'b1, 1'b0, st);

        // single-word frame, 3 bytes
        a0 = acc_cnt; l0 = last_cnt;
        st = {31'h1, 14'd3};
        send_frame(1, st, 1'b0, 16'd5, 1'b1);
        @(negedge clock);
        check_eq("one.words", acc_cnt - a0, 1);
        check_eq("one.last", last_cnt - l0, 1);
        pop_rec("one", 13'd3, 1'b0, 1'b0, st);

        // overflow: buffer stalls while word 3 is held, word 4 lost
        a0 = acc_cnt; l0 = last_cnt; o0 = ovf_cnt;
        st = {31'h0, 14'd40};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 3) m_ready = 1'b0;
            if (i == 4) begin
                check_eq("ovf.pulse", rx_w_overflow, 1);
                check_eq("ovf.held_valid", m_valid, 1);
                check_eq("ovf.held_last", m_last, 1);
                check_eq("ovf.held_data", m_data, {16'd6, 16'd2});
            end
            if (i == 5) check_eq("ovf.pulse_end", rx_w_overflow, 0);
            drive_word({16'd6, 16'(i)}, i == 0, i == 9, st, 1'b0);
        end
        @(negedge clock);
        idle_inputs();
        m_ready = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("ovf.words", acc_cnt - a0, 3);
        check_eq("ovf.last", last_cnt - l0, 1);
        check_eq("ovf.lastdata", last_data, {16'd6, 16'd2});
        check_eq("ovf.count", ovf_cnt - o0, 1);
        pop_rec("ovf", 13'd16, 1'b1, 1'b0, 45'd0);
        check_eq("ovf.one_rec", s_valid, 0);

        // flush at word 5, then a normal frame
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            drive_word({16'd7, 16'(i)}, i == 0, 1'b0, '0, 1'b0);
            rx_w_flush = (i == 4);
        end
        @(negedge clock);
        idle_inputs();
        st = {31'h3, 14'd8};
        send_frame(2, st, 1'b0, 16'd8, 1'b1);
        @(negedge clock);
        check_eq("flush.words", acc_cnt - a0, 6);
        pop_rec("flush", 13'd16, 1'b1, 1'b0, 45'd0);
        pop_rec("postflush", 13'd8, 1'b0, 1'b0, st);

        // sop mid-frame aborts the old frame
        send_frame(3, '0, 1'b0, 16'd9, 1'b0);
        st = {31'h0, 14'd8};
        send_frame(2, st, 1'b0, 16'd10, 1'b1);
        pop_rec("abort", 13'd12, 1'b1, 1'b0, 45'd0);
        pop_rec("after_abort", 13'd8, 1'b0, 1'b0, st);

        // queue full: 5 records, depth 4
        o0 = ovf_cnt;
        for (int k = 1; k <= 5; k++) begin
            send_frame(1, {31'h0, 14'(k)}, 1'b0, 16'(20 + k), 1'b1);
        end
        @(negedge clock);
        check_eq("qfull.ovf", ovf_cnt - o0, 1);
        for (int k = 1; k <= 4; k++) begin
            pop_rec("qfull", 13'(k), 1'b0, 1'b0, {31'h0, 14'(k)});
        end
        check_eq("qfull.empty", s_valid, 0);

        // saturation at MAX_FRAME
        st = {31'h0, 14'd8192};
        send_frame(2100, st, 1'b0, 16'd30, 1'b1);
        pop_rec("sat", 13'd8191, 1'b0, 1'b1, st);

        // mid-frame reset: queue holds one record, frame in flight
        send_frame(1, {31'h0, 14'd4}, 1'b0, 16'd40, 1'b1);
        check_eq("mrst.pre_valid", s_valid, 1);
        o0 = ovf_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive_word({16'd41, 16'(i)}, i == 0, 1'b0, '0, 1'b0);
        end
        @(negedge clock);
        idle_inputs();
        resetn = 1'b0;
        @(negedge clock);
        check_eq("mrst.m_valid", m_valid, 0);
        check_eq("mrst.m_data", m_data, 0);
        check_eq("mrst.m_last", m_last, 0);
        check_eq("mrst.s_valid", s_valid, 0);
        check_eq("mrst.ovf", rx_w_overflow, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("mrst.no_rec", s_valid, 0);
        check_eq("mrst.no_ovf", ovf_cnt - o0, 0);
        st = {31'h0, 14'd8};
        send_frame(2, st, 1'b0, 16'd42, 1'b1);
        pop_rec("mrst.next", 13'd8, 1'b0, 1'b0, st);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
